audio_dac_sample_buffer: RTL

//  Sample FIFO sitting directly upstream of audio_codec_transceiver on the DAC path.

---
 rtl/audio_dac_sample_buffer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/audio_dac_sample_buffer.sv
// Sample FIFO feeding the codec transceiver DAC path; inserts silence and counts underruns when starved.
// Latency: a write reaches dacdat_in two edges later when the buffer is empty; an advance shows the next sample one edge later.
// Backpressure: wr_ready drops when the FIFO holds DEPTH words; the output register adds one more slot.

// Generic synchronous FIFO with an occupancy count.
// Latency: a push is visible at pop_dat on the next cycle; there is no write-through to the read side.
// Backpressure: none internally; the caller gates push on full and pop on empty.
module sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  pop_dat,
    output logic [AW:0]   level
);
    localparam logic [AW:0]   LVL_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end
endmodule

module audio_dac_sample_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic             mute,
    input  logic             clr_stats,
    input  logic             dacdat_req,
    output logic [WIDTH-1:0] dacdat_in,
    output logic [AW:0]      level,
    output logic             underrun,
    output logic [CNT_W-1:0] underrun_cnt
);
    localparam logic [AW:0]      FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             req_d;
    logic             adv;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic             underrun_d;
    logic [WIDTH-1:0] fifo_dat;
    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] out_d;

    // Ready depends only on registered occupancy, so a pop cannot free a slot in the same cycle.
    assign wr_ready   = (level != FULL_LVL);
    assign push       = wr_valid & wr_ready;
    assign fifo_empty = (level == '0);
    assign adv        = dacdat_req & ~req_d;

    sync_fifo #(
        .W     (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (wr_data),
        .pop      (pop),
        .pop_dat  (fifo_dat),
        .level    (level)
    );

    always_comb begin
        state_d    = state_q;
        out_d      = out_reg;
        pop        = 1'b0;
        underrun_d = 1'b0;
        case (state_q)
            S_EMPTY: begin
                // The transceiver takes whatever is on the bus; with nothing loaded that is silence.
                underrun_d = adv;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    out_d   = fifo_dat;
                    state_d = S_FULL;
                end
            end
            S_FULL: begin
                if (adv) begin
                    if (!fifo_empty) begin
                        pop   = 1'b1;
                        out_d = fifo_dat;
                    end else begin
                        out_d   = '0;
                        state_d = S_EMPTY;
                    end
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_EMPTY;
            out_reg      <= '0;
            req_d        <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            state_q  <= state_d;
            out_reg  <= out_d;
            req_d    <= dacdat_req;
            underrun <= underrun_d;
            if (clr_stats) begin
                underrun_cnt <= '0;
            end else if (underrun_d && (underrun_cnt != '1)) begin
                underrun_cnt <= underrun_cnt + CNT_ONE;
            end
        end
    end

    assign dacdat_in = mute ? '0 : out_reg;
endmodule
